// File: rtl/multiplier_sa.sv
// Sequential shift-add multiply-accumulate: product = multiplicand * multiplier + addend.
// One multiplier bit per clock, stopping early once no set bits remain.
module multiplier_sa #(
    parameter int BITS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [BITS-1:0]   multiplicand,
    input  logic [BITS-1:0]   multiplier,
    input  logic [BITS-1:0]   addend,
    output logic              busy,
    output logic              done,
    output logic [2*BITS-1:0] product,
    output logic              upper_nz
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t              r_state;
    logic [2*BITS-1:0]   r_acc;
    logic [2*BITS-1:0]   r_mc;
    logic [BITS-1:0]     r_mp;
    logic                r_busy;
    logic                r_done;
    logic [2*BITS-1:0]   r_product;
    logic                r_upper_nz;

    logic [BITS-1:0]     w_mp_next;

    assign w_mp_next = r_mp >> 1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_mc       <= '0;
            r_mp       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_product  <= '0;
            r_upper_nz <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc  <= {{BITS{1'b0}}, addend};
                        r_mc   <= {{BITS{1'b0}}, multiplicand};
                        r_mp   <= multiplier;
                        r_busy <= 1'b1;
                        r_state <= (multiplier != '0) ? S_CALC : S_FINISH;
                    end
                end
                S_CALC: begin
                    // The sum cannot exceed 2*BITS bits, so no carry is kept.
                    if (r_mp[0]) begin
                        r_acc <= r_acc + r_mc;
                    end
                    r_mc <= r_mc << 1;
                    r_mp <= w_mp_next;
                    if (w_mp_next == '0) begin
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    r_product  <= r_acc;
                    r_upper_nz <= |r_acc[2*BITS-1:BITS];
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign product  = r_product;
    assign upper_nz = r_upper_nz;

endmodule

// File: tb/tb_multiplier_sa.sv
// Bench for multiplier_sa: directed vector table, random operands against an
// arithmetic reference, plus handshake and reset-abort sequences.
module tb_multiplier_sa;

    localparam int BITS = 16;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [BITS-1:0]   multiplicand;
    logic [BITS-1:0]   multiplier;
    logic [BITS-1:0]   addend;
    logic              busy;
    logic              done;
    logic [2*BITS-1:0] product;
    logic              upper_nz;

    multiplier_sa #(.BITS(BITS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .addend       (addend),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .upper_nz     (upper_nz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [2*BITS-1:0] last_prod;

    typedef struct {
        logic [BITS-1:0]   a;
        logic [BITS-1:0]   b;
        logic [BITS-1:0]   c;
        logic [2*BITS-1:0] exp_p;
        int                exp_lat;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic longint model_prod(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                                          input logic [BITS-1:0] c);
        longint r;
        r = longint'(a) * longint'(b) + longint'(c);
        return r;
    endfunction

    function automatic int model_lat(input logic [BITS-1:0] b);
        int n;
        n = 0;
        for (int i = 0; i < BITS; i++) begin
            if (b[i]) n = i + 1;
        end
        return n + 1;
    endfunction

    // Called at a negedge; returns just after the accept edge.
    task automatic launch(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                          input logic [BITS-1:0] c);
        multiplicand = a;
        multiplier   = b;
        addend       = c;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        multiplicand = BITS'($urandom);
        multiplier   = BITS'($urandom);
        addend       = BITS'($urandom);
        check("busy_after_accept", busy, 1);
    endtask

    // Counts edges after the accept edge until done is seen (at a negedge).
    // Optionally pulses start for one cycle at count inj while busy.
    task automatic wait_done(input int inj, output int lat, output bit got, output bit busy_ok,
                             output bit hold_ok);
        lat = 0;
        got = 1'b0;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        while (!got && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done) begin
                got = 1'b1;
            end else begin
                if (!busy) busy_ok = 1'b0;
                if (product !== last_prod) hold_ok = 1'b0;
                if (lat == inj) begin
                    start        = 1'b1;
                    multiplicand = 16'h0001;
                    multiplier   = 16'h0001;
                    addend       = 16'h0001;
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic do_op(input string name, input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                         input logic [BITS-1:0] c, input logic [2*BITS-1:0] exp_p,
                         input int exp_lat);
        int lat;
        bit got, busy_ok, hold_ok;
        launch(a, b, c);
        wait_done(-1, lat, got, busy_ok, hold_ok);
        check({name, "_done_seen"}, got, 1);
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_product"}, product, exp_p);
        check({name, "_upper_nz"}, upper_nz, (exp_p[2*BITS-1:BITS] != 0));
        check({name, "_busy_during"}, busy_ok, 1);
        check({name, "_product_held"}, hold_ok, 1);
        check({name, "_busy_at_done"}, busy, 0);
        last_prod = exp_p;
        @(negedge clk);
        check({name, "_done_single"}, done, 0);
    endtask

    vec_t vecs[6];

    initial begin
        int lat, cnt;
        bit got, busy_ok, hold_ok;
        logic [BITS-1:0] ra, rb, rc;

        vecs[0] = '{16'd1234, 16'd56,   16'd7,    32'd69111,      7};
        vecs[1] = '{16'h0ABC, 16'h0007, 16'h0004, 32'h0000_4B28,  4};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 32'hFFFF_0000, 17};
        vecs[3] = '{16'hFFFF, 16'h0000, 16'h0003, 32'h0000_0003,  1};
        vecs[4] = '{16'h0000, 16'h8000, 16'h0000, 32'h0000_0000, 17};
        vecs[5] = '{16'h8000, 16'h8000, 16'h0000, 32'h4000_0000, 17};

        rst_n = 1'b0;
        start = 1'b0;
        multiplicand = '0;
        multiplier = '0;
        addend = '0;
        last_prod = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_done", done, 0);
        check("reset_busy", busy, 0);
        check("reset_product", product, 0);
        check("reset_upper_nz", upper_nz, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c,
                  vecs[i].exp_p, vecs[i].exp_lat);
        end

        for (int i = 0; i < 40; i++) begin
            ra = BITS'($urandom);
            rb = BITS'($urandom >> ($urandom_range(0, 15)));
            rc = BITS'($urandom);
            do_op($sformatf("rand%0d", i), ra, rb, rc, model_prod(ra, rb, rc), model_lat(rb));
        end

        // start while busy is ignored
        launch(16'd1234, 16'd56, 16'd7);
        wait_done(2, lat, got, busy_ok, hold_ok);
        check("ignore_latency", lat, 7);
        check("ignore_product", product, 69111);
        last_prod = 32'd69111;
        cnt = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        check("ignore_no_second_op", cnt, 0);
        check("ignore_product_kept", product, 69111);

        // back-to-back: start in the done cycle
        launch(16'd3, 16'd5, 16'd1);
        wait_done(-1, lat, got, busy_ok, hold_ok);
        check("b2b_first_product", product, 16);
        last_prod = 32'd16;
        launch(16'd100, 16'd200, 16'd9);
        wait_done(-1, lat, got, busy_ok, hold_ok);
        check("b2b_second_seen", got, 1);
        check("b2b_second_latency", lat, model_lat(16'd200));
        check("b2b_second_product", product, 20009);
        last_prod = 32'd20009;
        @(negedge clk);

        // reset in the middle of CALC aborts
        launch(16'hFFFF, 16'hFFFF, 16'hFFFF);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_product", product, 0);
        check("abort_busy", busy, 0);
        check("abort_upper_nz", upper_nz, 0);
        cnt = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        check("abort_no_done", cnt, 0);
        last_prod = '0;
        do_op("after_abort", 16'h0ABC, 16'h0007, 16'h0004, 32'h0000_4B28, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
